// File: rtl/cq_viola_irqctrl_pkg.sv
// Shared constants for the cq_viola interrupt controller.
package cq_viola_irqctrl_pkg;

  localparam int IRQC_MAX_IRQ       = 16;
  localparam int IRQC_VEC_VALID_BIT = 15;

  localparam logic [2:0] IRQC_ADDR_PENDING = 3'd0;
  localparam logic [2:0] IRQC_ADDR_MASK    = 3'd1;
  localparam logic [2:0] IRQC_ADDR_MODE    = 3'd2;
  localparam logic [2:0] IRQC_ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] IRQC_ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] IRQC_ADDR_SWSET   = 3'd5;

  // Bit mask covering the implemented sources.
  function automatic logic [IRQC_MAX_IRQ-1:0] irqc_impl_mask(input int n);
    irqc_impl_mask = IRQC_MAX_IRQ'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/cq_viola_irqctrl_prienc.sv
// Lowest-index-wins 16-to-4 priority encoder; idx is 0 when nothing is requested.
module cq_viola_irqctrl_prienc
  import cq_viola_irqctrl_pkg::*;
(
  input  logic [IRQC_MAX_IRQ-1:0] req,
  output logic [3:0]              idx,
  output logic                    valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = IRQC_MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/cq_viola_irqctrl.sv
// Level/edge interrupt controller with Avalon-MM register access.
// Optional CQ_VIOLA_IRQCTRL_SYNC_EN adds a 2-flop input synchroniser per source.
module cq_viola_irqctrl
  import cq_viola_irqctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_vector
);

  localparam logic [IRQC_MAX_IRQ-1:0] IMPL = irqc_impl_mask(NUM_IRQ);

  // Registers are kept full width; unimplemented bits are forced to zero.
  logic [IRQC_MAX_IRQ-1:0] irq_ext;
  logic [IRQC_MAX_IRQ-1:0] s;
  logic [IRQC_MAX_IRQ-1:0] s_d;
  logic [IRQC_MAX_IRQ-1:0] pending_q;
  logic [IRQC_MAX_IRQ-1:0] mask_q;
  logic [IRQC_MAX_IRQ-1:0] mode_q;
  logic [IRQC_MAX_IRQ-1:0] active;
  logic [IRQC_MAX_IRQ-1:0] wdata;
  logic [IRQC_MAX_IRQ-1:0] w1c;
  logic [IRQC_MAX_IRQ-1:0] sw_set;
  logic [IRQC_MAX_IRQ-1:0] edge_next;
  logic [IRQC_MAX_IRQ-1:0] pending_next;
  logic [15:0]             rd_mux;
  logic [15:0]             vec_word;
  logic [3:0]              enc_idx;
  logic                    enc_valid;
  logic                    wr;

  assign irq_ext = IRQC_MAX_IRQ'(irq_in) & IMPL;

`ifdef CQ_VIOLA_IRQCTRL_SYNC_EN
  logic [IRQC_MAX_IRQ-1:0] sync1_q;
  logic [IRQC_MAX_IRQ-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_ext;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  // Synchronous sources: the single register is s_d, so edges land one cycle after the rise.
  assign s = irq_ext;
`endif

  assign wr     = chipselect & ~write_n;
  assign wdata  = writedata & IMPL;
  assign w1c    = (wr && address == IRQC_ADDR_PENDING) ? wdata : '0;
  assign sw_set = (wr && address == IRQC_ADDR_SWSET)   ? wdata : '0;
  assign active = pending_q & mask_q;

  // Set terms are OR-ed after the clear so a coincident set wins.
  assign edge_next    = (pending_q & ~w1c) | (s & ~s_d) | sw_set;
  assign pending_next = ((mode_q & edge_next) | (~mode_q & s)) & IMPL;

  cq_viola_irqctrl_prienc u_prienc (
    .req   (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    vec_word                     = '0;
    vec_word[IRQC_VEC_VALID_BIT] = enc_valid;
    vec_word[3:0]                = enc_idx;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      IRQC_ADDR_PENDING: rd_mux = pending_q;
      IRQC_ADDR_MASK:    rd_mux = mask_q;
      IRQC_ADDR_MODE:    rd_mux = mode_q;
      IRQC_ADDR_ACTIVE:  rd_mux = active;
      IRQC_ADDR_VECTOR:  rd_mux = vec_word;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_d        <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      readdata   <= '0;
      irq_out    <= 1'b0;
      irq_vector <= '0;
    end else begin
      s_d        <= s;
      pending_q  <= pending_next;
      readdata   <= rd_mux;
      irq_out    <= |active;
      irq_vector <= enc_idx;
      if (wr && address == IRQC_ADDR_MASK) mask_q <= wdata;
      if (wr && address == IRQC_ADDR_MODE) mode_q <= wdata;
    end
  end

endmodule

// File: tb/tb_cq_viola_irqctrl.sv
// Self-checking bench for cq_viola_irqctrl; register reads are scoreboarded.
module tb_cq_viola_irqctrl;

  localparam int NUM_IRQ = 8;
`ifdef CQ_VIOLA_IRQCTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [15:0] IMPL = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [2:0]         address = '0;
  logic               chipselect = 1'b0;
  logic               write_n = 1'b1;
  logic [15:0]        writedata = '0;
  logic [15:0]        readdata;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               irq_out;
  logic [3:0]         irq_vector;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic        rd_valid = 1'b0;

  cq_viola_irqctrl #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rd_valid <= chipselect & write_n;

  always @(negedge clk) begin
    if (rd_valid && exp_q.size() > 0) chk(tag_q.pop_front(), readdata, exp_q.pop_front());
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [15:0] e, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic o, input logic [3:0] v);
    chk({tag, "_irq_out"}, {15'b0, irq_out}, {15'b0, o});
    chk({tag, "_irq_vector"}, {12'b0, irq_vector}, {12'b0, v});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    chk_outs("rst", 1'b0, 4'd0);
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 16'h0000, $sformatf("rst_rd%0d", a));

    // single-cycle pulse on edge-mode bit 0
    wr_reg(3'd2, 16'h0001);
    wr_reg(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    step();
    irq_in[0] = 1'b0;
    repeat (LAT) step();
    chk_outs("pulse_early", 1'b0, 4'd0);
    step();
    chk_outs("pulse", 1'b1, 4'd0);
    rd_reg(3'd0, 16'h0001, "pulse_pending");
    wr_reg(3'd0, 16'h0001);
    rd_reg(3'd0, 16'h0000, "w1c_pending");
    chk_outs("w1c", 1'b0, 4'd0);

    // level mode on bit 3 ignores W1C
    wr_reg(3'd1, 16'h0008);
    irq_in[3] = 1'b1;
    repeat (LAT + 2) step();
    wr_reg(3'd0, 16'h0008);
    rd_reg(3'd0, 16'h0008, "lvl_w1c_ignored");
    chk_outs("lvl", 1'b1, 4'd3);
    irq_in[3] = 1'b0;
    repeat (LAT + 1) step();
    rd_reg(3'd0, 16'h0000, "lvl_release");
    chk_outs("lvl_release", 1'b0, 4'd0);

    // software set, priority and vector register
    wr_reg(3'd2, 16'h00FF);
    wr_reg(3'd1, 16'hFFFF);
    rd_reg(3'd1, IMPL, "mask_impl");
    wr_reg(3'd1, 16'h00FF);
    wr_reg(3'd5, 16'h0024);
    rd_reg(3'd3, 16'h0024, "sw_active");
    rd_reg(3'd4, 16'h8002, "sw_vector");
    rd_reg(3'd5, 16'h0000, "swset_rd");
    chk_outs("sw", 1'b1, 4'd2);
    wr_reg(3'd0, 16'h0004);
    rd_reg(3'd4, 16'h8005, "vec_after_w1c4");
    chk_outs("vec5", 1'b1, 4'd5);
    wr_reg(3'd0, 16'h0020);
    rd_reg(3'd4, 16'h0000, "vec_empty");
    chk_outs("vec_empty", 1'b0, 4'd0);

    // rising edge coincident with W1C: set wins
    irq_in[1] = 1'b1;
    repeat (LAT) step();
    wr_reg(3'd0, 16'h0002);
    rd_reg(3'd0, 16'h0002, "set_wins");
    irq_in[1] = 1'b0;
    repeat (LAT + 1) step();
    wr_reg(3'd0, 16'h0002);
    rd_reg(3'd0, 16'h0000, "set_wins_clear");

    // masked pending, then unmask
    wr_reg(3'd1, 16'h0000);
    wr_reg(3'd5, 16'h0004);
    step();
    chk_outs("masked", 1'b0, 4'd0);
    rd_reg(3'd3, 16'h0000, "masked_active");
    rd_reg(3'd0, 16'h0004, "masked_pending");
    wr_reg(3'd1, 16'h0004);
    chk_outs("unmask_same_edge", 1'b0, 4'd0);
    step();
    chk_outs("unmask", 1'b1, 4'd2);

    // reset beats a coincident write
    reset_n = 1'b0;
    address = 3'd1; writedata = 16'hFFFF; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    chk({"rst2_readdata"}, readdata, 16'h0000);
    chk_outs("rst2", 1'b0, 4'd0);
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 16'h0000, $sformatf("rst2_rd%0d", a));

    repeat (2) step();
    chk("sb_drain", 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
